drv_7seg_scan: RTL and testbench



---
 rtl/drv7seg_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 15 +
 rtl/drv_7seg_scan.sv | 170 +++++++++++++++++
 tb/tb_drv_7seg_scan.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/drv7seg_pkg.sv
// drv7seg_pkg: shared types, constants and helpers for the seven-segment scan driver.
// Segment encoding is active-low: bit 7 = decimal point, bits 6:0 = g..a.
package drv7seg_pkg;

    typedef logic [7:0] seg_t;

    // All segments and the decimal point off.
    localparam seg_t SEG_BLANK = 8'hFF;

    // Hex glyphs 0-F, active-low, decimal point (bit 7) held off.
    localparam seg_t GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Number of lit cycles in a slot for a brightness code. The usable
    // window is scaled by (code+1)/2**bright_w and floored, so the all-ones
    // code covers the whole window after the dead time.
    function automatic int unsigned calc_on_len(
        input int unsigned slot_cyc,
        input int unsigned dead_cyc,
        input int unsigned bright_w,
        input int unsigned bright
    );
        return ((slot_cyc - dead_cyc) * (bright + 1)) >> bright_w;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble + decimal point to active-low segment pattern.
module seg7_decode
    import drv7seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dot,
    output logic [7:0] seg
);

    // Look up the glyph and overlay the active-low decimal point.
    always_comb begin
        seg = {~dot, GLYPH[nibble][6:0]};
    end

endmodule

// File: rtl/drv_7seg_scan.sv
// drv_7seg_scan: time-multiplexed scan driver for N_DIGITS common-anode
// seven-segment digits with per-digit enable/blink/dot masks, PWM
// brightness, anti-ghosting dead time and a frame strobe.
// Optional build macro: DRV7SEG_LZB_EN enables leading-zero blanking.
module drv_7seg_scan
    import drv7seg_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned SLOT_CYC   = 50000,
    parameter int unsigned DEAD_CYC   = 4,
    parameter int unsigned BRIGHT_W   = 3,
    parameter int unsigned BLINK_LOG2 = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*N_DIGITS-1:0]   in_num,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic [N_DIGITS-1:0]     dot_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [7:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int unsigned SC_W  = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam logic [SC_W-1:0]  SLOT_LAST = SC_W'(SLOT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [SC_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]      idx;
    logic [BLINK_LOG2:0]   blink_cnt;
    logic                  blink_ph;
    logic                  slot_wrap;
    logic                  frame_wrap;
    logic                  sample_now;

    logic [N_DIGITS-1:0]   en_vec;

    // Per-slot sampled copies of the current digit's controls
    logic [3:0]            nibble_s;
    logic                  en_s;
    logic                  blink_s;
    logic                  dot_s;
    logic [BRIGHT_W-1:0]   bright_s;

    // Values in force for the current cycle (live inputs on the sampling cycle)
    logic [3:0]            nibble_live;
    logic [3:0]            nibble_e;
    logic                  en_e;
    logic                  blink_e;
    logic                  dot_e;
    logic [BRIGHT_W-1:0]   bright_e;

    logic [31:0]           slot_cnt_32;
    logic [31:0]           on_len;
    logic                  lit;
    logic [7:0]            seg_lit;
    logic [N_DIGITS-1:0]   an_lit;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (idx == IDX_LAST);
    assign sample_now = (slot_cnt == '0);
    assign blink_ph   = blink_cnt[BLINK_LOG2];

`ifdef DRV7SEG_LZB_EN
    logic [N_DIGITS-1:0] lz_vec;

    // Flag digits inside the unbroken run of zero nibbles from the top digit;
    // digit 0 and digits with a lit decimal point always stay visible.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_vec   = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run  = zero_run && (in_num[4*i +: 4] == 4'h0);
            lz_vec[i] = zero_run && !dot_mask[i];
        end
    end

    assign en_vec = digit_en & ~lz_vec;
`else
    assign en_vec = digit_en;
`endif

    assign nibble_live = in_num[{idx, 2'b00} +: 4];

    assign nibble_e = sample_now ? nibble_live      : nibble_s;
    assign en_e     = sample_now ? en_vec[idx]      : en_s;
    assign blink_e  = sample_now ? blink_mask[idx]  : blink_s;
    assign dot_e    = sample_now ? dot_mask[idx]    : dot_s;
    assign bright_e = sample_now ? brightness       : bright_s;

    // Slot timer, digit index and blink frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
        end else begin
            if (slot_wrap) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            if (frame_wrap) begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Capture the current digit's controls at the start of its slot so that
    // mid-slot input changes wait for the next slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nibble_s <= '0;
            en_s     <= 1'b0;
            blink_s  <= 1'b0;
            dot_s    <= 1'b0;
            bright_s <= '0;
        end else if (sample_now) begin
            nibble_s <= nibble_live;
            en_s     <= en_vec[idx];
            blink_s  <= blink_mask[idx];
            dot_s    <= dot_mask[idx];
            bright_s <= brightness;
        end
    end

    assign slot_cnt_32 = 32'(slot_cnt);
    assign on_len      = calc_on_len(SLOT_CYC, DEAD_CYC, BRIGHT_W, 32'(bright_e));
    // The dead window at the start of every slot keeps all anodes off
    // across each digit change.
    assign lit = (slot_cnt_32 >= DEAD_CYC) &&
                 (slot_cnt_32 < (DEAD_CYC + on_len)) &&
                 en_e && !(blink_e && blink_ph);

    seg7_decode u_decode (
        .nibble (nibble_e),
        .dot    (dot_e),
        .seg    (seg_lit)
    );

    // One-cold anode pattern for the current digit.
    always_comb begin
        an_lit      = '1;
        an_lit[idx] = 1'b0;
    end

    // Registered pin drive; segments are blanked whenever anodes are off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg        <= SEG_BLANK;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            if (lit) begin
                seg <= seg_lit;
                an  <= an_lit;
            end else begin
                seg <= SEG_BLANK;
                an  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_drv_7seg_scan.sv
// tb_drv_7seg_scan: directed vector table plus multi-cycle sequences for drv_7seg_scan.
// Build with DRV7SEG_LZB_EN defined to exercise leading-zero blanking.
module tb_drv_7seg_scan;

    localparam int N  = 4;
    localparam int SC = 16;
    localparam int DC = 2;
    localparam int BW = 2;
    localparam int BL = 0;

`ifdef DRV7SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [15:0]   in_num = '0;
    logic [3:0]    digit_en = '0;
    logic [3:0]    blink_mask = '0;
    logic [3:0]    dot_mask = '0;
    logic [1:0]    brightness = '0;
    logic [7:0]    seg;
    logic [3:0]    an;
    logic          frame_tick;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    drv_7seg_scan #(
        .N_DIGITS   (N),
        .SLOT_CYC   (SC),
        .DEAD_CYC   (DC),
        .BRIGHT_W   (BW),
        .BLINK_LOG2 (BL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_num     (in_num),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .dot_mask   (dot_mask),
        .brightness (brightness),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic [15:0] num;
        logic [3:0]  en;
        logic [3:0]  blink;
        logic [3:0]  dot;
        logic [1:0]  br;
        int          probe;
        logic [3:0]  exp_an;
        logic [7:0]  exp_seg;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic apply(input logic [15:0] num, input logic [3:0] en, input logic [3:0] bl,
                         input logic [3:0] dt, input logic [1:0] br);
        in_num     = num;
        digit_en   = en;
        blink_mask = bl;
        dot_mask   = dt;
        brightness = br;
    endtask

    // Reset held over two edges, released on a falling edge; the next
    // rising edge is the first counted cycle (g = 0).
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Leave the bench on the falling edge after the edge that registered
    // the outputs for counter state g.
    task automatic run_to(input int g);
        repeat (g + 1) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        int   first;
        int   lit_cnt[4];
        int   ft_pos[$];
        int   multi;
        int   c0, c1;
        int   an2_low, dp_bad, dp_low;

        // Reset state while reset is held from time zero
        @(negedge clk);
        check("reset_seg", seg, 8'hFF);
        check("reset_an", an, 4'hF);
        check("reset_ft", frame_tick, 1'b0);

        //               num      en    blink dot   br    g    an    seg
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd3, 0,   4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd3, 1,   4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd3, 2,   4'hE, 8'h99});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd3, 15,  4'hE, 8'h99});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd3, 16,  4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd3, 18,  4'hD, 8'hB0});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd3, 34,  4'hB, 8'hA4});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd3, 50,  4'h7, 8'hF9});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd3, 66,  4'hE, 8'h99});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd0, 4,   4'hE, 8'h99});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd0, 5,   4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h0, 2'd0, 20,  4'hD, 8'hB0});
        vecs.push_back('{16'h1234, 4'hF, 4'h2, 4'h0, 2'd3, 18,  4'hD, 8'hB0});
        vecs.push_back('{16'h1234, 4'hF, 4'h2, 4'h0, 2'd3, 82,  4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'hF, 4'h2, 4'h0, 2'd3, 146, 4'hD, 8'hB0});
        vecs.push_back('{16'h1234, 4'hF, 4'h2, 4'h0, 2'd3, 66,  4'hE, 8'h99});
        vecs.push_back('{16'h1234, 4'hB, 4'h0, 4'h0, 2'd3, 34,  4'hF, 8'hFF});
        vecs.push_back('{16'h1234, 4'hB, 4'h0, 4'h0, 2'd3, 50,  4'h7, 8'hF9});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h1, 2'd3, 2,   4'hE, 8'h19});
        vecs.push_back('{16'h1234, 4'hF, 4'h0, 4'h1, 2'd3, 18,  4'hD, 8'hB0});
        vecs.push_back('{16'h0050, 4'hF, 4'h0, 4'h0, 2'd3, 50,  LZB ? 4'hF : 4'h7, LZB ? 8'hFF : 8'hC0});
        vecs.push_back('{16'h0050, 4'hF, 4'h0, 4'h0, 2'd3, 34,  LZB ? 4'hF : 4'hB, LZB ? 8'hFF : 8'hC0});
        vecs.push_back('{16'h0050, 4'hF, 4'h0, 4'h0, 2'd3, 18,  4'hD, 8'h92});
        vecs.push_back('{16'h0050, 4'hF, 4'h0, 4'h0, 2'd3, 2,   4'hE, 8'hC0});
        vecs.push_back('{16'h0000, 4'hF, 4'h0, 4'h0, 2'd3, 18,  LZB ? 4'hF : 4'hD, LZB ? 8'hFF : 8'hC0});
        vecs.push_back('{16'h0000, 4'hF, 4'h0, 4'h0, 2'd3, 2,   4'hE, 8'hC0});
        vecs.push_back('{16'h0000, 4'hF, 4'h0, 4'h4, 2'd3, 34,  4'hB, 8'h40});

        foreach (vecs[i]) begin
            apply(vecs[i].num, vecs[i].en, vecs[i].blink, vecs[i].dot, vecs[i].br);
            do_reset();
            run_to(vecs[i].probe);
            check($sformatf("vec%0d_an", i), an, vecs[i].exp_an);
            check($sformatf("vec%0d_seg", i), seg, vecs[i].exp_seg);
        end

        // Asynchronous reset in the middle of a lit slot
        apply(16'h1234, 4'hF, 4'h0, 4'h0, 2'd3);
        do_reset();
        run_to(7);
        check("pre_reset_an", an, 4'hE);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_seg", seg, 8'hFF);
        check("async_rst_an", an, 4'hF);
        @(negedge clk);
        reset_n = 1'b1;
        first = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (an != 4'hF) begin
                first = k;
                break;
            end
        end
        check("first_lit_cycle", first, 2);
        check("first_lit_an", an, 4'hE);

        // Two full frames: lit cycles per digit, single active anode, frame strobe
        apply(16'h1234, 4'hF, 4'h0, 4'h0, 2'd3);
        do_reset();
        for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
        multi = 0;
        for (int g = 0; g < 128; g++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_tick) ft_pos.push_back(g);
            if ($countones(~an) > 1) multi++;
            for (int d = 0; d < 4; d++)
                if (!an[d] && g < 64) lit_cnt[d]++;
        end
        for (int d = 0; d < 4; d++) check($sformatf("lit_cnt_d%0d", d), lit_cnt[d], 14);
        check("multi_anode", multi, 0);
        check("ft_count", ft_pos.size(), 2);
        check("ft_first", (ft_pos.size() > 0) ? ft_pos[0] : -1, 63);
        check("ft_second", (ft_pos.size() > 1) ? ft_pos[1] : -1, 127);

        // Brightness change mid-slot waits for the next slot
        apply(16'h1234, 4'hF, 4'h0, 4'h0, 2'd3);
        do_reset();
        c0 = 0;
        c1 = 0;
        for (int g = 0; g < 32; g++) begin
            @(posedge clk);
            @(negedge clk);
            if (an != 4'hF) begin
                if (g < 16) c0++;
                else c1++;
            end
            if (g == 5) brightness = 2'd0;
        end
        check("bright_slot0", c0, 14);
        check("bright_slot1", c1, 3);

        // Disabled digit never lights; decimal point only with digit 0
        apply(16'h1234, 4'b1011, 4'h0, 4'b0001, 2'd3);
        do_reset();
        an2_low = 0;
        dp_bad  = 0;
        dp_low  = 0;
        for (int g = 0; g < 64; g++) begin
            @(posedge clk);
            @(negedge clk);
            if (!an[2]) an2_low++;
            if (!seg[7]) dp_low++;
            if ((!seg[7]) != (!an[0])) dp_bad++;
        end
        check("an2_never_low", an2_low, 0);
        check("dp_tracks_an0", dp_bad, 0);
        check("dp_low_cycles", dp_low, 14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
